// File: rtl/wb_arbiter_pkg.sv
// Shared widths, constants and the write-back payload type for the wb_arbiter slice.
package wb_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;

  localparam logic [DataW-1:0]    ZeroWord   = '0;
  localparam logic [RegAddrW-1:0] NOPRegAddr = '0;

  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic [DataW-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// md result buffer: wrap-bit pointers, head read-out and per-entry address match
// vectors so the arbiter can answer busy queries against queued writes.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  wb_entry_t           push_entry_i,
  input  logic                pop_i,
  output wb_entry_t           head_o,
  output logic                full_o,
  output logic                empty_o,
  input  logic [RegAddrW-1:0] q_addr_1_i,
  input  logic [RegAddrW-1:0] q_addr_2_i,
  output logic [DEPTH-1:0]    match_1_o,
  output logic [DEPTH-1:0]    match_2_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] count;
  logic            do_push, do_pop;
  wb_entry_t       mem_q [DEPTH];

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                   (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
  assign head_o  = mem_q[rd_ptr_q[IdxW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= push_entry_i;
  end

  // An entry is live when its distance from the read index is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [IdxW-1:0] offs;
    logic            live;
    assign offs         = IdxW'(g) - rd_ptr_q[IdxW-1:0];
    assign live         = ({1'b0, offs} < count);
    assign match_1_o[g] = live && (mem_q[g].addr == q_addr_1_i);
    assign match_2_o[g] = live && (mem_q[g].addr == q_addr_2_i);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: pipeline has priority, md results queue in
// wb_fifo, a starvation counter forces drain stalls. WB_BYPASS_EN enables md bypass.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_we,
  input  logic [RegAddrW-1:0] pipe_write_reg,
  input  logic [DataW-1:0]    pipe_write_data,
  output logic                pipe_stall,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [RegAddrW-1:0] md_write_reg,
  input  logic [DataW-1:0]    md_write_data,
  input  logic [RegAddrW-1:0] q_addr_1,
  input  logic [RegAddrW-1:0] q_addr_2,
  output logic                q_busy_1,
  output logic                q_busy_2,
  output logic                wb_we,
  output logic [RegAddrW-1:0] wb_write_reg,
  output logic [DataW-1:0]    wb_write_data
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0]       starve_q, starve_d;
  logic                  wb_we_q, wb_we_d;
  wb_entry_t             wb_q, wb_d;
  wb_entry_t             head, md_entry;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, pipe_take, md_fire, bypass;
  logic [FIFO_DEPTH-1:0] match_1, match_2;

  assign md_entry   = '{addr: md_write_reg, data: md_write_data};
  assign md_ready   = !fifo_full;
  assign md_fire    = md_valid && md_ready && (md_write_reg != NOPRegAddr);
  assign pipe_stall = (starve_q == CntW'(STARVE_LIMIT));
  assign pipe_take  = !pipe_stall && pipe_we && (pipe_write_reg != NOPRegAddr);
  assign pop        = !fifo_empty && (pipe_stall || !pipe_take);

`ifdef WB_BYPASS_EN
  assign bypass = fifo_empty && !pipe_stall && !pipe_take && md_fire;
`else
  assign bypass = 1'b0;
`endif

  assign push = md_fire && !bypass;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (md_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .q_addr_1_i   (q_addr_1),
    .q_addr_2_i   (q_addr_2),
    .match_1_o    (match_1),
    .match_2_o    (match_2)
  );

  // Source select for the write port; address/data hold when nothing is written.
  always_comb begin
    wb_we_d  = 1'b0;
    wb_d     = wb_q;
    starve_d = '0;
    if (pop) begin
      wb_we_d = 1'b1;
      wb_d    = head;
    end else begin
      if (!fifo_empty) starve_d = starve_q + CntW'(1);
      if (pipe_take) begin
        wb_we_d = 1'b1;
        wb_d    = '{addr: pipe_write_reg, data: pipe_write_data};
      end else if (bypass) begin
        wb_we_d = 1'b1;
        wb_d    = md_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q  <= 1'b0;
      wb_q     <= '{addr: NOPRegAddr, data: ZeroWord};
      starve_q <= '0;
    end else begin
      wb_we_q  <= wb_we_d;
      wb_q     <= wb_d;
      starve_q <= starve_d;
    end
  end

  assign q_busy_1 = (q_addr_1 != NOPRegAddr) &&
                    ((|match_1) || (md_fire && (md_write_reg == q_addr_1)));
  assign q_busy_2 = (q_addr_2 != NOPRegAddr) &&
                    ((|match_2) || (md_fire && (md_write_reg == q_addr_2)));

  assign wb_we         = wb_we_q;
  assign wb_write_reg  = wb_q.addr;
  assign wb_write_data = wb_q.data;

endmodule
